// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Defaults describe the 50 MHz board build; benches override with SIM_TICK_DIV.
package sw_debounce_pkg;

    localparam int SW_WIDTH         = 9;
    localparam int DEB_TICK_DIV_50M = 50000;
    localparam int DEB_STABLE_N     = 8;
    localparam int SIM_TICK_DIV     = 4;

    typedef enum logic [1:0] {
        HIST_MIXED = 2'd0,
        HIST_ALL0  = 2'd1,
        HIST_ALL1  = 2'd2
    } hist_kind_e;

    // Classify the low n bits of a sample history (n in 2..16).
    function automatic hist_kind_e hist_state(input logic [15:0] hist, input int n);
        logic [15:0] mask;
        mask = 16'hFFFF >> (16 - n);
        if ((hist & mask) == mask) begin
            return HIST_ALL1;
        end else if ((hist & mask) == 16'h0000) begin
            return HIST_ALL0;
        end else begin
            return HIST_MIXED;
        end
    endfunction

endpackage

// File: rtl/sw_debounce_sync2.sv
// Two-flop synchroniser for asynchronous inputs (switches, buttons, ps2).
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // First stage may go metastable; only the second stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/sw_debounce.sv
// Synchronises and debounces the switch bank; emits a stable level plus
// registered rise/fall/changed strobes and the shared sample tick.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH    = SW_WIDTH,
    parameter int TICK_DIV = DEB_TICK_DIV_50M,
    parameter int STABLE_N = DEB_STABLE_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    output logic             tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [WIDTH-1:0]    sync_q_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_next_s;
    logic                tick_r;
    logic [STABLE_N-1:0] hist_r      [WIDTH];
    logic [STABLE_N-1:0] hist_next_s [WIDTH];
    hist_kind_e          kind_s      [WIDTH];
    logic [WIDTH-1:0]    db_r;
    logic [WIDTH-1:0]    rise_r;
    logic [WIDTH-1:0]    fall_r;
    logic                changed_r;
    logic [WIDTH-1:0]    rise_next_s;
    logic [WIDTH-1:0]    fall_next_s;

    sync2 #(.W(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (sw_raw),
        .q     (sync_q_s)
    );

    // Prescaler next count, wrapping at TICK_DIV-1.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
    end

    // tick_r is registered from the next count so it is high exactly while cnt_r == TICK_DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_LAST);
        end
    end

    // Per-bit acceptance judged on the history as it will look after this tick's shift.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign hist_next_s[i] = {hist_r[i][STABLE_N-2:0], sync_q_s[i]};
        assign kind_s[i]      = hist_state(16'(hist_next_s[i]), STABLE_N);
        assign rise_next_s[i] = tick_r && (kind_s[i] == HIST_ALL1) && !db_r[i];
        assign fall_next_s[i] = tick_r && (kind_s[i] == HIST_ALL0) &&  db_r[i];
    end

    // Histories, level flops and strobes; strobes land in the same cycle as the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_r[i] <= {STABLE_N{1'b0}};
            end
            db_r      <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tick_r) begin
                    hist_r[i] <= hist_next_s[i];
                end
            end
            db_r      <= (db_r | rise_next_s) & ~fall_next_s;
            rise_r    <= rise_next_s;
            fall_r    <= fall_next_s;
            changed_r <= |(rise_next_s | fall_next_s);
        end
    end

    assign sw_db   = db_r;
    assign sw_rise = rise_r;
    assign sw_fall = fall_r;
    assign changed = changed_r;
    assign tick    = tick_r;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, STABLE_N=4.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W  = SW_WIDTH;
    localparam int SN = 4;
    localparam int LAT_MAX = 2 + (SN + 1) * SIM_TICK_DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw_raw = 9'h1FF;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         changed, tick;

    int n_chk = 0;
    int n_err = 0;

    int rise_tot [W];
    int fall_tot [W];
    int chg_tot   = 0;
    int chg_bad   = 0;
    int width_bad = 0;
    logic [W-1:0] prev_rise = '0;
    logic [W-1:0] prev_fall = '0;

    sw_debounce #(.WIDTH(W), .TICK_DIV(SIM_TICK_DIV), .STABLE_N(SN)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .changed (changed),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < W; i++) begin
            rise_tot[i] = 0;
            fall_tot[i] = 0;
        end
    end

    // Pulse bookkeeping and per-cycle strobe invariants.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                rise_tot[i] <= rise_tot[i] + int'(sw_rise[i]);
                fall_tot[i] <= fall_tot[i] + int'(sw_fall[i]);
            end
            chg_tot <= chg_tot + int'(changed);
            if (changed !== |(sw_rise | sw_fall)) chg_bad <= chg_bad + 1;
            if (((sw_rise & prev_rise) | (sw_fall & prev_fall)) != '0) width_bad <= width_bad + 1;
            prev_rise <= sw_rise;
            prev_fall <= sw_fall;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_db(input logic [W-1:0] mask, input logic [W-1:0] val,
                           input int budget, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if ((sw_db & mask) == val) ok = 1'b1;
        end
    endtask

    function automatic int enc83(input logic [7:0] x);
        int y = 0;
        for (int i = 0; i < 8; i++) if (x[i]) y = i;
        return y;
    endfunction

    function automatic int sum_fall();
        int s = 0;
        for (int i = 0; i < W; i++) s += fall_tot[i];
        return s;
    endfunction

    initial begin
        int   cyc, bad, r0, f0, c0, tk;
        logic ok;
        logic [11:0] pat;

        // 1: reset held with all switches high
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({sw_db, sw_rise, sw_fall, changed, tick} != '0) bad++;
        end
        chk("rst_quiet", bad, 0);
        chk("rst_db", sw_db, 9'h000);
        rst = 1'b1;
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = tick;
        end
        chk("tick_phase", pat, 12'h444);
        wait_db(9'h1FF, 9'h1FF, LAT_MAX - 12, cyc, ok);
        chk("t1_db", sw_db, 9'h1FF);
        chk("t1_rise", sw_rise, 9'h1FF);
        chk("t1_changed", changed, 1'b1);
        chk("t1_fall", sw_fall, 9'h000);
        step(1);
        chk("t1_rise_off", sw_rise, 9'h000);
        chk("t1_changed_off", changed, 1'b0);

        // 2: clean step on bit 3
        sw_raw = 9'h000;
        wait_db(9'h1FF, 9'h000, 40, cyc, ok);
        chk("t2_setup", ok, 1'b1);
        sw_raw = 9'h008;
        wait_db(9'h1FF, 9'h008, LAT_MAX, cyc, ok);
        chk("t2_lat", ok, 1'b1);
        chk("t2_rise", sw_rise, 9'h008);
        chk("t2_fall", sw_fall, 9'h000);
        step(1);
        chk("t2_rise_off", sw_rise, 9'h000);

        // 3: bounce on bit 0, then settle high
        step(1);
        r0 = rise_tot[0];
        f0 = sum_fall();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) sw_raw[0] = ~sw_raw[0];
            @(negedge clk);
            if (sw_db[0]) bad++;
        end
        chk("t3_held_low", bad, 0);
        sw_raw[0] = 1'b1;
        wait_db(9'h001, 9'h001, LAT_MAX, cyc, ok);
        chk("t3_lat", ok, 1'b1);
        step(2);
        chk("t3_rise_cnt", rise_tot[0] - r0, 1);
        chk("t3_fall_cnt", sum_fall() - f0, 0);
        chk("t3_db", sw_db, 9'h009);

        // 4: simultaneous rise and fall
        sw_raw = 9'h0F0;
        wait_db(9'h1FF, 9'h0F0, 40, cyc, ok);
        chk("t4_setup", ok, 1'b1);
        step(1);
        c0 = chg_tot;
        sw_raw = 9'h10F;
        wait_db(9'h1FF, 9'h10F, LAT_MAX, cyc, ok);
        chk("t4_lat", ok, 1'b1);
        chk("t4_rise", sw_rise, 9'h10F);
        chk("t4_fall", sw_fall, 9'h0F0);
        chk("t4_changed", changed, 1'b1);
        chk("t4_en", sw_db[8], 1'b1);
        chk("t4_x", sw_db[7:0], 8'h0F);
        chk("t4_y", enc83(sw_db[7:0]), 3);
        step(1);
        chk("t4_chg_once", chg_tot - c0, 1);

        // 5: two-cycle glitch on a stable high bit
        sw_raw = 9'h020;
        wait_db(9'h1FF, 9'h020, 40, cyc, ok);
        chk("t5_setup", ok, 1'b1);
        step(1);
        f0 = fall_tot[5];
        sw_raw[5] = 1'b0;
        step(2);
        sw_raw[5] = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sw_db[5]) bad++;
        end
        chk("t5_held_high", bad, 0);
        chk("t5_no_fall", fall_tot[5] - f0, 0);

        // 6: reset in the middle of a debounce window
        sw_raw = 9'h024;
        tk = 0;
        for (int i = 0; i < 20 && tk < 2; i++) begin
            @(negedge clk);
            if (tick) tk++;
        end
        chk("t6_pre_ticks", tk, 2);
        chk("t6_pre_db", sw_db[2], 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_rst_db", sw_db, 9'h000);
        step(2);
        rst = 1'b1;
        tk = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sw_db[2]) ok = 1'b1;
            else if (tick) tk++;
        end
        chk("t6_rise_seen", ok, 1'b1);
        chk("t6_ticks", tk, 4);
        chk("t6_rise", sw_rise, 9'h024);
        step(2);

        chk("changed_eq_or", chg_bad, 0);
        chk("strobe_width", width_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
